// File: rtl/mem_reader_if.sv
// Frame-buffer read port and downstream FIFO write port of the frame reader.
// The master side is the reader; the slave side is the buffer/FIFO pair.
interface mem_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
);
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  almostfull;
  logic                  sof;
  logic                  eof;

  modport master (
    output ren,
    output raddr,
    input  rdata,
    output wr,
    output wdata,
    input  almostfull,
    output sof,
    output eof
  );

  modport slave (
    input  ren,
    input  raddr,
    output rdata,
    input  wr,
    input  wdata,
    output almostfull,
    input  sof,
    input  eof
  );
endinterface

// File: rtl/mem_reader.sv
// Streams one frame from a synchronous frame buffer into a downstream FIFO,
// throttled by the FIFO almost-full flag, with sof/eof tags and a frame counter.
module mem_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int BRAM_DEPTH = 307200,
  parameter int ADDR_WIDTH = 19
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_frame_valid,
  mem_reader_if.master  if_mem,
  output logic          o_busy,
  output logic [7:0]    o_frame_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ren_p0;
  logic                  w_ren_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr_p0;
  logic [ADDR_WIDTH-1:0] w_raddr_nxt;
  logic                  r_vld_p1;
  logic                  r_sof_p1;
  logic                  r_eof_p1;
  logic                  w_sof_nxt;
  logic                  w_eof_nxt;
  logic                  w_last;
  logic [7:0]            r_frame_count;
  logic [7:0]            w_frame_count_nxt;

  always_comb begin
    w_last            = (r_raddr_p0 == LAST_ADDR);
    w_state_nxt       = r_state;
    w_ren_nxt         = 1'b0;
    w_raddr_nxt       = r_raddr_p0;
    w_sof_nxt         = r_ren_p0 && (r_raddr_p0 == '0);
    w_eof_nxt         = r_ren_p0 && w_last;
    w_frame_count_nxt = r_frame_count + 8'(w_eof_nxt);

    case (r_state)
      S_IDLE: begin
        if (i_frame_valid && !if_mem.almostfull) begin
          w_state_nxt = S_ACTIVE;
          w_ren_nxt   = 1'b1;
          w_raddr_nxt = '0;
        end
      end
      S_ACTIVE: begin
        // The last read ends the frame outright so no address past the end is issued.
        if (r_ren_p0 && w_last) begin
          w_state_nxt = S_IDLE;
          w_ren_nxt   = 1'b0;
          w_raddr_nxt = '0;
        end else begin
          if (r_ren_p0) begin
            w_raddr_nxt = r_raddr_p0 + ONE_ADDR;
          end
          w_ren_nxt = !if_mem.almostfull;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // p0: read issue stage -> p1: buffer data returned, FIFO write stage
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state    <= S_IDLE;
      r_ren_p0   <= 1'b0;
      r_raddr_p0 <= '0;
      r_vld_p1   <= 1'b0;
      r_sof_p1   <= 1'b0;
      r_eof_p1   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ren_p0   <= w_ren_nxt;
      r_raddr_p0 <= w_raddr_nxt;
      r_vld_p1   <= r_ren_p0;
      r_sof_p1   <= w_sof_nxt;
      r_eof_p1   <= w_eof_nxt;
    end
  end

  // Counter moves together with eof so both are visible in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_count <= 8'd0;
    end else if (!i_flush) begin
      r_frame_count <= w_frame_count_nxt;
    end
  end

  assign if_mem.ren   = r_ren_p0;
  assign if_mem.raddr = r_raddr_p0;
  assign if_mem.wr    = r_vld_p1;
  assign if_mem.wdata = if_mem.rdata;
  assign if_mem.sof   = r_sof_p1;
  assign if_mem.eof   = r_eof_p1;
  assign o_busy        = (r_state == S_ACTIVE) || r_vld_p1;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with a 16-pixel frame whose buffer returns the address as data.
module tb_mem_reader;

  localparam int DW = 12;
  localparam int AW = 5;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       fv;
  logic       busy;
  logic [7:0] fcount;

  mem_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  mem_reader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_frame_valid (fv),
    .if_mem        (bus_if),
    .o_busy        (busy),
    .o_frame_count (fcount)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wq[$];
  bit sofq[$];
  bit eofq[$];
  int wcyc[$];
  int rq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous frame buffer: data is the address, one cycle after the read.
  always @(posedge clk) begin
    if (bus_if.ren) bus_if.rdata <= DW'(bus_if.raddr);
  end

  // Record every write and read issued, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus_if.wr) begin
      wq.push_back(int'(bus_if.wdata));
      sofq.push_back(bus_if.sof);
      eofq.push_back(bus_if.eof);
      wcyc.push_back(cyc);
    end
    if (bus_if.ren) rq.push_back(int'(bus_if.raddr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq.delete(); sofq.delete(); eofq.delete(); wcyc.delete(); rq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus_if.ren !== 1'b0) begin n_err++; $display("FAIL reset_ren got %b want 0", bus_if.ren); end
    n_vec++; if (bus_if.raddr !== 5'd0) begin n_err++; $display("FAIL reset_raddr got %0d want 0", bus_if.raddr); end
    n_vec++; if (bus_if.wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", bus_if.wr); end
    n_vec++; if (bus_if.sof !== 1'b0 || bus_if.eof !== 1'b0) begin n_err++; $display("FAIL reset_sof_eof got %b%b want 00", bus_if.sof, bus_if.eof); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (fcount !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fcount); end
  endtask

  task automatic test_free_run();
    int nsof;
    clear_q();
    fv = 1'b1;
    tick();
    n_vec++; if (bus_if.ren !== 1'b1 || bus_if.raddr !== 5'd0) begin n_err++; $display("FAIL fr_first_read got ren=%b addr=%0d want ren=1 addr=0", bus_if.ren, bus_if.raddr); end
    n_vec++; if (bus_if.wr !== 1'b0) begin n_err++; $display("FAIL fr_no_early_wr got %b want 0", bus_if.wr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fr_busy got %b want 1", busy); end
    fv = 1'b0;
    tick();
    n_vec++; if (bus_if.wr !== 1'b1 || bus_if.wdata !== 12'd0 || bus_if.sof !== 1'b1 || bus_if.eof !== 1'b0) begin
      n_err++; $display("FAIL fr_first_wr got wr=%b d=%0d sof=%b eof=%b want 1 0 1 0", bus_if.wr, bus_if.wdata, bus_if.sof, bus_if.eof); end
    n_vec++; if (bus_if.ren !== 1'b1 || bus_if.raddr !== 5'd1) begin n_err++; $display("FAIL fr_second_read got ren=%b addr=%0d want 1 1", bus_if.ren, bus_if.raddr); end
    repeat (20) tick();
    n_vec++; if (wq.size() !== 16) begin n_err++; $display("FAIL fr_wr_count got %0d want 16", wq.size()); end
    n_vec++; if (rq.size() !== 16) begin n_err++; $display("FAIL fr_rd_count got %0d want 16", rq.size()); end
    nsof = 0;
    for (int i = 0; i < wq.size() && i < 16; i++) begin
      n_vec++; if (wq[i] !== i) begin n_err++; $display("FAIL fr_data[%0d] got %0d want %0d", i, wq[i], i); end
      n_vec++; if (eofq[i] !== (i == 15)) begin n_err++; $display("FAIL fr_eof[%0d] got %b want %b", i, eofq[i], (i == 15)); end
      n_vec++; if (wcyc[i] !== wcyc[0] + i) begin n_err++; $display("FAIL fr_consecutive[%0d] got cycle %0d want %0d", i, wcyc[i], wcyc[0] + i); end
      nsof += int'(sofq[i]);
    end
    n_vec++; if (nsof !== 1) begin n_err++; $display("FAIL fr_sof_count got %0d want 1", nsof); end
    for (int i = 0; i < rq.size() && i < 16; i++) begin
      n_vec++; if (rq[i] !== i) begin n_err++; $display("FAIL fr_raddr[%0d] got %0d want %0d", i, rq[i], i); end
    end
    n_vec++; if (fcount !== 8'd1) begin n_err++; $display("FAIL fr_count got %0d want 1", fcount); end
    n_vec++; if (busy !== 1'b0 || bus_if.ren !== 1'b0 || bus_if.raddr !== 5'd0) begin
      n_err++; $display("FAIL fr_idle_after got busy=%b ren=%b addr=%0d want 0 0 0", busy, bus_if.ren, bus_if.raddr); end
  endtask

  task automatic test_almostfull();
    bit found;
    clear_q();
    fv = 1'b1;
    tick();
    fv = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.ren === 1'b1 && bus_if.raddr === 5'd6) begin found = 1'b1; break; end
      tick();
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL af_reach_addr6 got %b want 1", found); end
    n_vec++; if (wq.size() !== 5) begin n_err++; $display("FAIL af_writes_before got %0d want 5", wq.size()); end
    bus_if.almostfull = 1'b1;
    repeat (5) tick();
    n_vec++; if (wq.size() !== 7) begin n_err++; $display("FAIL af_writes_after_rise got %0d want 7", wq.size()); end
    n_vec++; if (bus_if.ren !== 1'b0 || bus_if.raddr !== 5'd7) begin n_err++; $display("FAIL af_held got ren=%b addr=%0d want 0 7", bus_if.ren, bus_if.raddr); end
    n_vec++; if (bus_if.wr !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL af_stalled got wr=%b busy=%b want 0 1", bus_if.wr, busy); end
    bus_if.almostfull = 1'b0;
    tick();
    n_vec++; if (bus_if.ren !== 1'b1 || bus_if.raddr !== 5'd7) begin n_err++; $display("FAIL af_resume got ren=%b addr=%0d want 1 7", bus_if.ren, bus_if.raddr); end
    repeat (30) tick();
    n_vec++; if (wq.size() !== 16) begin n_err++; $display("FAIL af_total got %0d want 16", wq.size()); end
    for (int i = 0; i < wq.size() && i < 16; i++) begin
      n_vec++; if (wq[i] !== i) begin n_err++; $display("FAIL af_data[%0d] got %0d want %0d", i, wq[i], i); end
    end
    n_vec++; if (sofq[0] !== 1'b1 || eofq[15] !== 1'b1) begin n_err++; $display("FAIL af_tags got sof=%b eof=%b want 1 1", sofq[0], eofq[15]); end
    n_vec++; if (fcount !== 8'd2) begin n_err++; $display("FAIL af_count got %0d want 2", fcount); end
  endtask

  task automatic test_back_to_back();
    int starts;
    int nsof;
    int neof;
    do_reset();
    clear_q();
    fv = 1'b1;
    starts = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus_if.ren === 1'b1 && bus_if.raddr === 5'd0) starts++;
      if (starts == 3) break;
    end
    fv = 1'b0;
    n_vec++; if (starts !== 3) begin n_err++; $display("FAIL b2b_starts got %0d want 3", starts); end
    repeat (25) tick();
    n_vec++; if (fcount !== 8'd3) begin n_err++; $display("FAIL b2b_count got %0d want 3", fcount); end
    n_vec++; if (wq.size() !== 48) begin n_err++; $display("FAIL b2b_writes got %0d want 48", wq.size()); end
    nsof = 0;
    neof = 0;
    for (int i = 0; i < wq.size() && i < 48; i++) begin
      n_vec++; if (wq[i] !== i % 16) begin n_err++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, wq[i], i % 16); end
      nsof += int'(sofq[i]);
      neof += int'(eofq[i]);
    end
    n_vec++; if (nsof !== 3 || neof !== 3) begin n_err++; $display("FAIL b2b_tags got sof=%0d eof=%0d want 3 3", nsof, neof); end
    n_vec++; if (sofq[16] !== 1'b1 || sofq[32] !== 1'b1) begin n_err++; $display("FAIL b2b_sof_pos got %b %b want 1 1", sofq[16], sofq[32]); end
    n_vec++; if (wcyc[16] - wcyc[15] !== 2 || wcyc[32] - wcyc[31] !== 2) begin
      n_err++; $display("FAIL b2b_gap got %0d %0d want 2 2", wcyc[16] - wcyc[15], wcyc[32] - wcyc[31]); end
  endtask

  task automatic test_flush();
    bit found;
    clear_q();
    fv = 1'b1;
    tick();
    fv = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.ren === 1'b1 && bus_if.raddr === 5'd9) begin found = 1'b1; break; end
      tick();
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL fl_reach_addr9 got %b want 1", found); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (bus_if.ren !== 1'b0 || bus_if.wr !== 1'b0 || bus_if.raddr !== 5'd0) begin
      n_err++; $display("FAIL fl_outputs got ren=%b wr=%b addr=%0d want 0 0 0", bus_if.ren, bus_if.wr, bus_if.raddr); end
    n_vec++; if (busy !== 1'b0 || bus_if.sof !== 1'b0 || bus_if.eof !== 1'b0) begin
      n_err++; $display("FAIL fl_status got busy=%b sof=%b eof=%b want 0 0 0", busy, bus_if.sof, bus_if.eof); end
    n_vec++; if (fcount !== 8'd3) begin n_err++; $display("FAIL fl_count_kept got %0d want 3", fcount); end
    repeat (3) tick();
    n_vec++; if (wq.size() !== 9) begin n_err++; $display("FAIL fl_no_late_wr got %0d want 9", wq.size()); end
    clear_q();
    fv = 1'b1;
    tick();
    n_vec++; if (bus_if.ren !== 1'b1 || bus_if.raddr !== 5'd0) begin n_err++; $display("FAIL fl_restart got ren=%b addr=%0d want 1 0", bus_if.ren, bus_if.raddr); end
    fv = 1'b0;
    tick();
    n_vec++; if (bus_if.wr !== 1'b1 || bus_if.sof !== 1'b1 || bus_if.wdata !== 12'd0) begin
      n_err++; $display("FAIL fl_restart_sof got wr=%b sof=%b d=%0d want 1 1 0", bus_if.wr, bus_if.sof, bus_if.wdata); end
    repeat (20) tick();
    n_vec++; if (wq.size() !== 16 || fcount !== 8'd4) begin n_err++; $display("FAIL fl_frame_done got n=%0d cnt=%0d want 16 4", wq.size(), fcount); end
  endtask

  task automatic test_reset_active();
    clear_q();
    fv = 1'b1;
    tick();
    fv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_if.almostfull = k[0];
      tick();
    end
    rst = 1'b1;
    bus_if.almostfull = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.almostfull = 1'b0;
    n_vec++; if (bus_if.ren !== 1'b0 || bus_if.wr !== 1'b0 || bus_if.raddr !== 5'd0) begin
      n_err++; $display("FAIL ra_outputs got ren=%b wr=%b addr=%0d want 0 0 0", bus_if.ren, bus_if.wr, bus_if.raddr); end
    n_vec++; if (busy !== 1'b0 || bus_if.sof !== 1'b0 || bus_if.eof !== 1'b0) begin
      n_err++; $display("FAIL ra_status got busy=%b sof=%b eof=%b want 0 0 0", busy, bus_if.sof, bus_if.eof); end
    n_vec++; if (fcount !== 8'd0) begin n_err++; $display("FAIL ra_count got %0d want 0", fcount); end
    clear_q();
    for (int k = 0; k < 10; k++) begin
      bus_if.almostfull = k[0];
      tick();
    end
    bus_if.almostfull = 1'b0;
    n_vec++; if (wq.size() !== 0 || rq.size() !== 0) begin n_err++; $display("FAIL ra_quiet got wr=%0d rd=%0d want 0 0", wq.size(), rq.size()); end
  endtask

  task automatic test_af_from_reset();
    bus_if.almostfull = 1'b1;
    fv = 1'b1;
    do_reset();
    clear_q();
    repeat (6) tick();
    n_vec++; if (rq.size() !== 0 || bus_if.ren !== 1'b0) begin n_err++; $display("FAIL afr_blocked got reads=%0d ren=%b want 0 0", rq.size(), bus_if.ren); end
    bus_if.almostfull = 1'b0;
    tick();
    n_vec++; if (bus_if.ren !== 1'b1 || bus_if.raddr !== 5'd0) begin n_err++; $display("FAIL afr_first_read got ren=%b addr=%0d want 1 0", bus_if.ren, bus_if.raddr); end
    fv = 1'b0;
    repeat (25) tick();
    n_vec++; if (fcount !== 8'd1 || wq.size() !== 16) begin n_err++; $display("FAIL afr_frame got cnt=%0d n=%0d want 1 16", fcount, wq.size()); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fv = 1'b0;
    bus_if.almostfull = 1'b0;
    bus_if.rdata = '0;
    test_reset();
    test_free_run();
    test_almostfull();
    test_back_to_back();
    test_flush();
    test_reset_active();
    test_af_from_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
